// File: rtl/alu_pkg.sv
// Shared opcode map, FSM state type and iterative-engine op select for multicycle_alu.
// Pure declarations: no latency, no flow control.
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_XOR  = 4'b0001;
  localparam logic [3:0] OP_SLL  = 4'b0010;
  localparam logic [3:0] OP_ADD  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0100;
  localparam logic [3:0] OP_MUL  = 4'b0101;
  localparam logic [3:0] OP_ADD2 = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_DIVU = 4'b1000;
  localparam logic [3:0] OP_REMU = 4'b1001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    MD_MUL  = 2'd0,
    MD_DIVU = 2'd1,
    MD_REMU = 2'd2
  } md_op_t;

  function automatic logic is_iterative(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

  function automatic md_op_t to_md_op(input logic [3:0] op);
    if (op == OP_MUL) begin
      return MD_MUL;
    end else if (op == OP_DIVU) begin
      return MD_DIVU;
    end
    return MD_REMU;
  endfunction

endpackage

// File: rtl/iter_muldiv.sv
// Iterative shift-add multiply / restoring divide, one bit per cycle, WIDTH cycles after start.
// done_o pulses with result_o valid in the final iteration cycle; no backpressure (caller captures it).
module iter_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  md_op_t           op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic             busy_q;
  logic [CW-1:0]    cnt_q;
  md_op_t           op_q;
  // acc: product accumulator or partial remainder; x: multiplicand or divisor;
  // y: multiplier or dividend shifting out while quotient bits shift in.
  logic [WIDTH-1:0] acc_q, x_q, y_q;
  logic [WIDTH-1:0] acc_d, x_d, y_d;
  logic [WIDTH:0]   r_sh;
  logic             take;

  always_comb begin
    r_sh  = {acc_q, y_q[WIDTH-1]};
    take  = (r_sh >= {1'b0, x_q});
    acc_d = acc_q;
    x_d   = x_q;
    y_d   = y_q;
    if (op_q == MD_MUL) begin
      acc_d = acc_q + (y_q[0] ? x_q : '0);
      x_d   = x_q << 1;
      y_d   = y_q >> 1;
    end else begin
      // A zero divisor always "takes": quotient fills with ones, remainder ends as the dividend.
      acc_d = take ? (r_sh[WIDTH-1:0] - x_q) : r_sh[WIDTH-1:0];
      y_d   = {y_q[WIDTH-2:0], take};
    end
  end

  assign done_o   = busy_q && (cnt_q == LAST);
  assign result_o = (op_q == MD_DIVU) ? y_d : acc_d;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      op_q   <= MD_MUL;
      acc_q  <= '0;
      x_q    <= '0;
      y_q    <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
      op_q   <= op_i;
      acc_q  <= '0;
      if (op_i == MD_MUL) begin
        x_q <= a_i;
        y_q <= b_i;
      end else begin
        x_q <= b_i;
        y_q <= a_i;
      end
    end else if (busy_q) begin
      acc_q <= acc_d;
      x_q   <= x_d;
      y_q   <= y_d;
      cnt_q <= done_o ? '0 : cnt_q + 1'b1;
      if (done_o) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/multicycle_alu.sv
// Multicycle ALU: single-cycle logic/arith/shift ops (latency 1), MUL/DIVU/REMU iterative (latency WIDTH+1).
// One op in flight; ready_o only in IDLE, result held in DONE until ready_i, new accept one cycle later.
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  input  logic [3:0]       ALUCtrl_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic             Zero_o
);

  localparam int SHW = $clog2(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] alu_result;
  logic [SHW-1:0]   shamt;
  logic             alu_load;
  logic             md_start;
  logic             md_done;
  logic [WIDTH-1:0] md_result;

  assign shamt = data2_i[SHW-1:0];

  always_comb begin
    alu_result = data1_i + data2_i;
    case (ALUCtrl_i)
      OP_AND:  alu_result = data1_i & data2_i;
      OP_XOR:  alu_result = data1_i ^ data2_i;
      OP_SLL:  alu_result = data1_i << shamt;
      OP_SUB:  alu_result = data1_i - data2_i;
      OP_SRA:  alu_result = $signed(data1_i) >>> shamt;
      default: alu_result = data1_i + data2_i;
    endcase
  end

  iter_muldiv #(
    .WIDTH(WIDTH)
  ) u_muldiv (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (md_start),
    .op_i    (to_md_op(ALUCtrl_i)),
    .a_i     (data1_i),
    .b_i     (data2_i),
    .done_o  (md_done),
    .result_o(md_result)
  );

  always_comb begin
    state_d  = state_q;
    ready_o  = 1'b0;
    valid_o  = 1'b0;
    md_start = 1'b0;
    alu_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ready_o = 1'b1;
        if (valid_i) begin
          if (is_iterative(ALUCtrl_i)) begin
            md_start = 1'b1;
            state_d  = ST_BUSY;
          end else begin
            alu_load = 1'b1;
            state_d  = ST_DONE;
          end
        end
      end
      ST_BUSY: begin
        if (md_done) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        valid_o = 1'b1;
        // Consuming goes back to IDLE; ready_o is low here so nothing is accepted this cycle.
        if (ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (alu_load) begin
        data_q <= alu_result;
      end else if ((state_q == ST_BUSY) && md_done) begin
        data_q <= md_result;
      end
    end
  end

  assign data_o = data_q;
  assign Zero_o = (data_q == '0);

endmodule

// File: tb/tb_multicycle_alu.sv
module tb_multicycle_alu;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [31:0] data1_i = '0;
  logic [31:0] data2_i = '0;
  logic [3:0]  ALUCtrl_i = '0;
  logic        valid_o;
  logic        ready_i = 1'b0;
  logic [31:0] data_o;
  logic        Zero_o;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_result = '0;

  multicycle_alu #(.WIDTH(32)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .data1_i  (data1_i),
    .data2_i  (data2_i),
    .ALUCtrl_i(ALUCtrl_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .data_o   (data_o),
    .Zero_o   (Zero_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    sa = a;
    case (op)
      4'd0:    ref_alu = a & b;
      4'd1:    ref_alu = a ^ b;
      4'd2:    ref_alu = a << b[4:0];
      4'd4:    ref_alu = a - b;
      4'd5:    ref_alu = a * b;
      4'd7:    ref_alu = sa >>> b[4:0];
      4'd8:    ref_alu = (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'd9:    ref_alu = (b == 0) ? a : a % b;
      default: ref_alu = a + b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [3:0] op);
    return (op == 4'd5 || op == 4'd8 || op == 4'd9) ? 33 : 1;
  endfunction

  // Issues one op at the current negedge, waits for the result, optionally stalls, then consumes it.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int stall, input bit hold_valid,
                        output logic [31:0] res, output logic zero, output int lat);
    checks++;
    if (ready_o !== 1'b1) begin
      errors++;
      $display("FAIL issue_ready: ready_o=%b required 1", ready_o);
    end
    ALUCtrl_i = op; data1_i = a; data2_i = b; valid_i = 1'b1;
    @(posedge clk_i); #1;
    valid_i = hold_valid;
    data1_i = $urandom; data2_i = $urandom; ALUCtrl_i = 4'($urandom_range(0, 15));
    lat = 0;
    do begin
      @(negedge clk_i);
      lat++;
      if (valid_o !== 1'b1) begin
        checks++;
        if (data_o !== last_result || ready_o !== 1'b0) begin
          errors++;
          $display("FAIL busy_hold: data_o=%h ready_o=%b required data_o=%h ready_o=0",
                   data_o, ready_o, last_result);
        end
      end
    end while (valid_o !== 1'b1 && lat < 200);
    if (valid_o !== 1'b1) begin
      errors++;
      $display("FAIL timeout: valid_o=%b after %0d cycles, required 1", valid_o, lat);
    end
    res = data_o; zero = Zero_o;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk_i);
      checks++;
      if (data_o !== res || Zero_o !== zero || valid_o !== 1'b1 || ready_o !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold: data_o=%h Zero_o=%b valid_o=%b ready_o=%b required %h %b 1 0",
                 data_o, Zero_o, valid_o, ready_o, res, zero);
      end
    end
    valid_i = 1'b0; ready_i = 1'b1;
    @(posedge clk_i); #1;
    ready_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
      errors++;
      $display("FAIL consume: ready_o=%b valid_o=%b required 1 0", ready_o, valid_o);
    end
    last_result = res;
  endtask

  task automatic test_reset();
    #2 rst_i = 1'b0;
    #1;
    checks++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0 || data_o !== 32'h0 || Zero_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_values: ready_o=%b valid_o=%b data_o=%h Zero_o=%b required 1 0 0 1",
               ready_o, valid_o, data_o, Zero_o);
    end
    valid_i = 1'b1; ALUCtrl_i = 4'd3; data1_i = 32'd1; data2_i = 32'd1;
    repeat (3) @(negedge clk_i);
    checks++;
    if (valid_o !== 1'b0 || data_o !== 32'h0 || ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_hold: valid_o=%b data_o=%h ready_o=%b required 0 0 1", valid_o, data_o, ready_o);
    end
    valid_i = 1'b0;
    rst_i = 1'b1;
    last_result = '0;
  endtask

  task automatic test_single_cycle();
    logic [3:0]  op_t [9];
    logic [31:0] a_t [9];
    logic [31:0] b_t [9];
    logic [31:0] e_t [9];
    logic [31:0] res;
    logic        z;
    int          lat;
    op_t = '{4'd3, 4'd4, 4'd0, 4'd1, 4'd2, 4'd2, 4'd7, 4'd6, 4'd12};
    a_t  = '{32'h7FFF_FFFF, 32'd5, 32'hF0F0_1234, 32'hFFFF_0000, 32'h1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'd1, 32'hFFFF_FFFF};
    b_t  = '{32'h1, 32'd5, 32'h0FF0_FFFF, 32'h0F0F_0F0F, 32'h24, 32'h0, 32'h20, 32'd2, 32'd2};
    e_t  = '{32'h8000_0000, 32'h0, 32'h00F0_1234, 32'hF0F0_0F0F, 32'h10, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'd3, 32'd1};
    for (int i = 0; i < 9; i++) begin
      run_op(op_t[i], a_t[i], b_t[i], 0, 1'b0, res, z, lat);
      checks += 3;
      if (res !== e_t[i]) begin
        errors++;
        $display("FAIL single_value[%0d]: data_o=%h required %h", i, res, e_t[i]);
      end
      if (z !== (e_t[i] == 32'h0)) begin
        errors++;
        $display("FAIL single_zero[%0d]: Zero_o=%b required %b", i, z, (e_t[i] == 32'h0));
      end
      if (lat != 1) begin
        errors++;
        $display("FAIL single_latency[%0d]: %0d cycles required 1", i, lat);
      end
    end
  endtask

  task automatic test_muldiv();
    logic [3:0]  op_t [5];
    logic [31:0] a_t [5];
    logic [31:0] b_t [5];
    logic [31:0] e_t [5];
    logic [31:0] res;
    logic        z;
    int          lat;
    op_t = '{4'd5, 4'd8, 4'd9, 4'd8, 4'd9};
    a_t  = '{32'hFFFF_FFFF, 32'd100, 32'd100, 32'd9, 32'd9};
    b_t  = '{32'd3, 32'd7, 32'd7, 32'd0, 32'd0};
    e_t  = '{32'hFFFF_FFFD, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'd9};
    for (int i = 0; i < 5; i++) begin
      run_op(op_t[i], a_t[i], b_t[i], 0, 1'b0, res, z, lat);
      checks += 3;
      if (res !== e_t[i]) begin
        errors++;
        $display("FAIL muldiv_value[%0d]: data_o=%h required %h", i, res, e_t[i]);
      end
      if (z !== 1'b0) begin
        errors++;
        $display("FAIL muldiv_zero[%0d]: Zero_o=%b required 0", i, z);
      end
      if (lat != 33) begin
        errors++;
        $display("FAIL muldiv_latency[%0d]: %0d cycles required 33", i, lat);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] res;
    logic        z;
    int          lat;
    run_op(4'd7, 32'h8000_0000, 32'd4, 5, 1'b1, res, z, lat);
    checks += 2;
    if (res !== 32'hF800_0000 || z !== 1'b0) begin
      errors++;
      $display("FAIL sra_backpressure: data_o=%h Zero_o=%b required f8000000 0", res, z);
    end
    if (lat != 1) begin
      errors++;
      $display("FAIL sra_latency: %0d cycles required 1", lat);
    end
  endtask

  task automatic test_random();
    logic [3:0]  op;
    logic [31:0] a, b, exp_v;
    logic [31:0] res;
    logic        z;
    int          lat;
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'h0;
        1:       b = 32'($urandom_range(1, 255));
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) a = b;
      exp_v = ref_alu(op, a, b);
      run_op(op, a, b, $urandom_range(0, 3), 1'($urandom_range(0, 1)), res, z, lat);
      checks += 3;
      if (res !== exp_v) begin
        errors++;
        $display("FAIL random_value[%0d] op=%0d a=%h b=%h: data_o=%h required %h", i, op, a, b, res, exp_v);
      end
      if (z !== (exp_v == 32'h0)) begin
        errors++;
        $display("FAIL random_zero[%0d]: Zero_o=%b required %b", i, z, (exp_v == 32'h0));
      end
      if (lat != ref_latency(op)) begin
        errors++;
        $display("FAIL random_latency[%0d] op=%0d: %0d cycles required %0d", i, op, lat, ref_latency(op));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  sc_ops [12];
    logic [3:0]  op;
    logic [31:0] expq [$];
    logic [31:0] e;
    int          nres = 0;
    sc_ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd7, 4'd10, 4'd11, 4'd13, 4'd14, 4'd15};
    ready_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) @(negedge clk_i);
      if (ready_o === 1'b1 && valid_o === 1'b1) begin
        errors++;
        $display("FAIL b2b_exclusive: ready_o and valid_o both 1 at cycle %0d", i);
      end
      if (valid_o === 1'b1) begin
        e = (expq.size() > 0) ? expq.pop_front() : 32'hx;
        nres++;
        checks++;
        if (data_o !== e) begin
          errors++;
          $display("FAIL b2b_value[%0d]: data_o=%h required %h", nres, data_o, e);
        end
      end
      if (ready_o === 1'b1) begin
        op = sc_ops[$urandom_range(0, 11)];
        ALUCtrl_i = op; data1_i = $urandom; data2_i = $urandom; valid_i = 1'b1;
        expq.push_back(ref_alu(op, data1_i, data2_i));
      end
    end
    valid_i = 1'b0;
    @(negedge clk_i);
    ready_i = 1'b0;
    last_result = data_o;
    checks += 2;
    if (nres != 10) begin
      errors++;
      $display("FAIL b2b_count: %0d results in 20 cycles required 10", nres);
    end
    if (expq.size() != 0 || ready_o !== 1'b1) begin
      errors++;
      $display("FAIL b2b_drain: %0d pending ready_o=%b required 0 pending ready_o=1", expq.size(), ready_o);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] res;
    logic        z;
    int          lat;
    int          spurious;
    // reset 10 cycles into a MUL
    ALUCtrl_i = 4'd5; data1_i = 32'd1234; data2_i = 32'd5678; valid_i = 1'b1;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    repeat (10) @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    checks++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0 || data_o !== 32'h0 || Zero_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_busy: ready_o=%b valid_o=%b data_o=%h Zero_o=%b required 1 0 0 1",
               ready_o, valid_o, data_o, Zero_o);
    end
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    last_result = '0;
    ready_i = 1'b1;
    spurious = 0;
    repeat (40) begin
      @(negedge clk_i);
      if (valid_o !== 1'b0 || ready_o !== 1'b1) spurious++;
    end
    ready_i = 1'b0;
    checks++;
    if (spurious != 0) begin
      errors++;
      $display("FAIL reset_mid_no_result: %0d cycles with valid_o=1 or ready_o=0, required 0", spurious);
    end
    // reset while a result is held in DONE
    ALUCtrl_i = 4'd1; data1_i = 32'h0000_00FF; data2_i = 32'h0000_0F0F; valid_i = 1'b1;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (valid_o !== 1'b1 || data_o !== 32'h0000_0FF0) begin
      errors++;
      $display("FAIL pre_reset_done: valid_o=%b data_o=%h required 1 00000ff0", valid_o, data_o);
    end
    rst_i = 1'b0;
    #1;
    checks++;
    if (valid_o !== 1'b0 || data_o !== 32'h0 || Zero_o !== 1'b1 || ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_done: valid_o=%b data_o=%h Zero_o=%b ready_o=%b required 0 0 1 1",
               valid_o, data_o, Zero_o, ready_o);
    end
    @(negedge clk_i);
    rst_i = 1'b1;
    run_op(4'd3, 32'd2, 32'd3, 0, 1'b0, res, z, lat);
    checks++;
    if (res !== 32'd5 || lat != 1) begin
      errors++;
      $display("FAIL post_reset_op: data_o=%h latency=%0d required 00000005 1", res, lat);
    end
  endtask

  initial begin
    test_reset();
    test_single_cycle();
    test_muldiv();
    test_backpressure();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width; legal values are 8, 16, 32 and 64.
REQ-002 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port valid_i, input, 1 bit: operation request valid.
REQ-005 SHALL have port ready_o, output, 1 bit: block can accept a request.
REQ-006 SHALL have port data1_i, input, WIDTH bits: operand A, signed for SRA and unsigned for DIVU/REMU.
REQ-007 SHALL have port data2_i, input, WIDTH bits: operand B; for shifts, only the low $clog2(WIDTH) bits are used.
REQ-008 SHALL have port ALUCtrl_i, input, 4 bits: opcode.
REQ-009 SHALL have port valid_o, output, 1 bit: result valid.
REQ-010 SHALL have port ready_i, input, 1 bit: consumer accepts the result.
REQ-011 SHALL have port data_o, output, WIDTH bits: result.
REQ-012 SHALL have port Zero_o, output, 1 bit: 1 when data_o is all zeros, otherwise 0.

Function
REQ-013 SHALL decode the opcode as follows: 0000 AND, 0001 XOR, 0010 SLL, 0011 ADD, 0100 SUB, 0101 MUL, 0110 ADD, 0111 SRA, 1000 DIVU, 1001 REMU; opcodes 1010-1111 SHALL execute ADD.
REQ-014 SHALL accept a request on any cycle where valid_i and ready_o are both 1, registering the operands and opcode at that edge; later changes to the inputs SHALL NOT affect the operation in flight.
REQ-015 SHALL implement a three-state FSM with states IDLE, BUSY and DONE; ready_o SHALL be 1 only in IDLE, and valid_o SHALL be 1 only in DONE.
REQ-016 SHALL transition IDLE->DONE on accept of a single-cycle opcode (every opcode except MUL, DIVU and REMU), giving a latency of 1 cycle.
REQ-017 SHALL transition IDLE->BUSY on accept of MUL, DIVU or REMU, stay in BUSY for exactly WIDTH cycles, then go to DONE, giving a latency of WIDTH+1 cycles.
REQ-018 SHALL transition DONE->IDLE on the cycle ready_i is 1; while ready_i is 0, data_o, Zero_o and valid_o SHALL hold unchanged indefinitely.
REQ-019 SHALL NOT accept a new request in the same cycle a result is consumed, giving a minimum issue interval of 2 cycles.
REQ-020 SHALL compute MUL by iterative shift-add, one bit per cycle, returning the low WIDTH bits of the product; signed and unsigned operands give identical low bits.
REQ-021 SHALL compute DIVU and REMU by restoring division, one quotient bit per cycle.
REQ-022 SHALL, for divide-by-zero, return a quotient of all ones for DIVU and the dividend for REMU, still taking WIDTH+1 cycles.
REQ-023 SHALL wrap ADD and SUB modulo 2^WIDTH without any overflow flag.
REQ-024 SHALL make SRA sign-fill and SLL zero-fill; a shift amount of 0 returns data1_i unchanged.
REQ-025 SHALL ignore valid_i while in BUSY or DONE, with no queuing of requests.
REQ-026 SHALL keep data_o stable outside DONE, holding the last result, and SHALL keep Zero_o consistent with data_o at all times.

Reset
REQ-027 SHALL, while rst_i is 0, force the FSM to IDLE, the cycle counter to 0, data_o to 0, Zero_o to 1, valid_o to 0 and ready_o to 1, asynchronously.
REQ-028 SHALL abandon any operation in flight when reset is asserted mid-BUSY or mid-DONE, with no result delivered afterwards.
REQ-029 SHALL begin accepting requests on the first rising clock edge after rst_i deasserts.

Structure
REQ-030 SHALL place the opcode localparams and the FSM state typedef in a shared package, alu_pkg.
REQ-031 SHALL put the iterative multiply/divide engine in one sub-module, iter_muldiv, with start/done handshaking, WIDTH parameter and counter; single-cycle ops stay in the top level.

Verification
REQ-032 SHALL cover ADD: 0x7FFFFFFF + 1 with ready_i=1 -> valid_o one cycle after accept, data_o=0x80000000, Zero_o=0.
REQ-033 SHALL cover SUB to zero: 5 - 5 -> data_o=0, Zero_o=1.
REQ-034 SHALL cover MUL: 0xFFFFFFFF * 3 -> valid_o exactly 33 cycles after accept, data_o=0xFFFFFFFD.
REQ-035 SHALL cover division: DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 9/0 -> 0xFFFFFFFF; REMU 9/0 -> 9.
REQ-036 SHALL cover back-pressure and shifts: SRA 0x80000000 by 4 with ready_i held 0 for 5 cycles -> data_o=0xF8000000 held stable, valid_o=1 throughout, ready_o=0, IDLE one cycle after ready_i=1.
REQ-037 SHALL cover reset mid-operation: assert rst_i low 10 cycles into a MUL -> outputs immediately take reset values, and no valid_o appears after release until a new request.
